// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit beside the execute stage.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef EXE_MUL_OP
`define EXE_MUL_OP    8'b1100_0000
`endif
`ifndef EXE_MULH_OP
`define EXE_MULH_OP   8'b1100_0001
`endif
`ifndef EXE_MULHSU_OP
`define EXE_MULHSU_OP 8'b1100_0010
`endif
`ifndef EXE_MULHU_OP
`define EXE_MULHU_OP  8'b1100_0011
`endif
`ifndef EXE_DIV_OP
`define EXE_DIV_OP    8'b1100_0100
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP   8'b1100_0101
`endif
`ifndef EXE_REM_OP
`define EXE_REM_OP    8'b1100_0110
`endif
`ifndef EXE_REMU_OP
`define EXE_REMU_OP   8'b1100_0111
`endif

module ex_muldiv (
    input  logic             clk,
    input  logic             rst,
    input  logic [`AluOpBus] ex_aluop,
    input  logic [31:0]      ex_reg1,
    input  logic [31:0]      ex_reg2,
    input  logic [4:0]       ex_wd,
    input  logic             ex_wreg,
    input  logic             flush,
    output logic             md_stallreq,
    output logic             md_valid,
    output logic [31:0]      md_result,
    output logic [4:0]       md_wd,
    output logic             md_wreg
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [`AluOpBus] op_q;
    logic [4:0]       wd_q;
    logic             wreg_q;
    logic             mul_q;
    logic             neg_q;
    logic             neg_r;
    logic [4:0]       cnt;
    logic [63:0]      acc;
    logic [63:0]      mcand;
    logic [31:0]      shreg;

    logic        in_mop;
    logic        in_mul;
    logic        a_sgn;
    logic        b_sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic        fast_mul;
    logic        accept;
    logic        shortcut;

    logic [32:0] rem_sh;
    logic        take;
    logic [31:0] diff;

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] remv;
    logic [31:0] res;

    // Operand signedness per op; anything unlisted is not an M-op.
    always_comb begin
        in_mop = 1'b1;
        in_mul = 1'b0;
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        case (ex_aluop)
            `EXE_MUL_OP: begin
                in_mul = 1'b1;
                a_sgn  = 1'b1;
                b_sgn  = 1'b1;
            end
            `EXE_MULH_OP: begin
                in_mul = 1'b1;
                a_sgn  = 1'b1;
                b_sgn  = 1'b1;
            end
            `EXE_MULHSU_OP: begin
                in_mul = 1'b1;
                a_sgn  = 1'b1;
            end
            `EXE_MULHU_OP: begin
                in_mul = 1'b1;
            end
            `EXE_DIV_OP, `EXE_REM_OP: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            `EXE_DIVU_OP, `EXE_REMU_OP: begin
                in_mop = 1'b1;
            end
            default: begin
                in_mop = 1'b0;
            end
        endcase
    end

    assign a_mag = (a_sgn && ex_reg1[31]) ? (~ex_reg1 + 32'd1) : ex_reg1;
    assign b_mag = (b_sgn && ex_reg2[31]) ? (~ex_reg2 + 32'd1) : ex_reg2;

    assign div_zero = in_mop && !in_mul && (ex_reg2 == 32'd0);
    assign div_ovf  = in_mop && !in_mul && a_sgn
                   && (ex_reg1 == 32'h8000_0000)
                   && (ex_reg2 == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = in_mop && in_mul;
`else
    assign fast_mul = 1'b0;
`endif

    assign accept   = (state == IDLE) && in_mop && !flush;
    assign shortcut = div_zero || div_ovf || fast_mul;

    // One restoring-division step: remainder lives in acc[31:0],
    // dividend bits shift out of shreg while quotient bits shift in.
    assign rem_sh = {acc[31:0], shreg[31]};
    assign take   = rem_sh >= {1'b0, mcand[31:0]};
    assign diff   = rem_sh[31:0] - mcand[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        md_stallreq = 1'b0;
        md_valid    = 1'b0;
        md_result   = 32'd0;
        md_wd       = 5'd0;
        md_wreg     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    md_stallreq = 1'b1;
                    state_nx    = shortcut ? DONE : CALC;
                end
            end
            CALC: begin
                md_stallreq = 1'b1;
                if (cnt == 5'd31) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (!flush) begin
                    md_valid  = 1'b1;
                    md_result = res;
                    md_wd     = wd_q;
                    md_wreg   = wreg_q;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
        if (rst) begin
            md_stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            wd_q   <= 5'd0;
            wreg_q <= 1'b0;
            mul_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            shreg  <= 32'd0;
        end else if (accept) begin
            op_q   <= ex_aluop;
            wd_q   <= ex_wd;
            wreg_q <= ex_wreg;
            mul_q  <= in_mul;
            cnt    <= 5'd0;
            neg_q  <= (a_sgn & ex_reg1[31]) ^ (b_sgn & ex_reg2[31]);
            neg_r  <= a_sgn & ex_reg1[31];
            mcand  <= {32'd0, in_mul ? a_mag : b_mag};
            shreg  <= in_mul ? b_mag : a_mag;
            acc    <= 64'd0;
            if (div_zero) begin
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                shreg <= 32'hFFFF_FFFF;
                acc   <= {32'd0, ex_reg1};
            end else if (div_ovf) begin
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                shreg <= 32'h8000_0000;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (fast_mul) begin
                acc <= {32'd0, a_mag} * {32'd0, b_mag};
            end
`endif
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            if (mul_q) begin
                if (shreg[0]) begin
                    acc <= acc + mcand;
                end
                mcand <= {mcand[62:0], 1'b0};
                shreg <= {1'b0, shreg[31:1]};
            end else begin
                acc   <= {32'd0, take ? diff : rem_sh[31:0]};
                shreg <= {shreg[30:0], take};
            end
        end
    end

    // Sign fix-up of the magnitude results and final selection.
    always_comb begin
        prod = neg_q ? (~acc + 64'd1) : acc;
        quo  = neg_q ? (~shreg + 32'd1) : shreg;
        remv = neg_r ? (~acc[31:0] + 32'd1) : acc[31:0];
        res  = 32'd0;
        case (op_q)
            `EXE_MUL_OP: begin
                res = prod[31:0];
            end
            `EXE_MULH_OP, `EXE_MULHSU_OP, `EXE_MULHU_OP: begin
                res = prod[63:32];
            end
            `EXE_DIV_OP, `EXE_DIVU_OP: begin
                res = quo;
            end
            `EXE_REM_OP, `EXE_REMU_OP: begin
                res = remv;
            end
            default: begin
                res = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors for ex_muldiv against an arithmetic
// reference model, with cycle-by-cycle output checks.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef EXE_MUL_OP
`define EXE_MUL_OP    8'b1100_0000
`endif
`ifndef EXE_MULH_OP
`define EXE_MULH_OP   8'b1100_0001
`endif
`ifndef EXE_MULHSU_OP
`define EXE_MULHSU_OP 8'b1100_0010
`endif
`ifndef EXE_MULHU_OP
`define EXE_MULHU_OP  8'b1100_0011
`endif
`ifndef EXE_DIV_OP
`define EXE_DIV_OP    8'b1100_0100
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP   8'b1100_0101
`endif
`ifndef EXE_REM_OP
`define EXE_REM_OP    8'b1100_0110
`endif
`ifndef EXE_REMU_OP
`define EXE_REMU_OP   8'b1100_0111
`endif

module tb_ex_muldiv;

    localparam logic [7:0] NOP = 8'h00;

    logic             clk = 1'b0;
    logic             rst;
    logic [`AluOpBus] ex_aluop;
    logic [31:0]      ex_reg1;
    logic [31:0]      ex_reg2;
    logic [4:0]       ex_wd;
    logic             ex_wreg;
    logic             flush;
    logic             md_stallreq;
    logic             md_valid;
    logic [31:0]      md_result;
    logic [4:0]       md_wd;
    logic             md_wreg;

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en = 1'b0;
    logic        exp_valid;
    logic        exp_stall;
    logic        chk_stall;
    logic [31:0] exp_res;
    logic [4:0]  exp_wd;
    logic        exp_wreg;
    int          cur_cyc;
    string       tag;

    ex_muldiv dut (
        .clk         (clk),
        .rst         (rst),
        .ex_aluop    (ex_aluop),
        .ex_reg1     (ex_reg1),
        .ex_reg2     (ex_reg2),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .flush       (flush),
        .md_stallreq (md_stallreq),
        .md_valid    (md_valid),
        .md_result   (md_result),
        .md_wd       (md_wd),
        .md_wreg     (md_wreg)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [7:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sub;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sub = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        model = 32'd0;
        case (op)
            `EXE_MUL_OP:    begin p = sa * sb;  model = p[31:0];  end
            `EXE_MULH_OP:   begin p = sa * sb;  model = p[63:32]; end
            `EXE_MULHSU_OP: begin p = sa * sub; model = p[63:32]; end
            `EXE_MULHU_OP:  begin p = ua * ub;  model = p[63:32]; end
            `EXE_DIV_OP: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (ovf) model = 32'h8000_0000;
                else begin p = sa / sb; model = p[31:0]; end
            end
            `EXE_REM_OP: begin
                if (b == 0) model = a;
                else if (ovf) model = 32'd0;
                else begin p = sa % sb; model = p[31:0]; end
            end
            `EXE_DIVU_OP: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else begin p = ua / ub; model = p[31:0]; end
            end
            `EXE_REMU_OP: begin
                if (b == 0) model = a;
                else begin p = ua % ub; model = p[31:0]; end
            end
            default: model = 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [7:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic is_div;
        is_div = (op == `EXE_DIV_OP) || (op == `EXE_DIVU_OP)
              || (op == `EXE_REM_OP) || (op == `EXE_REMU_OP);
        if (is_div && b == 0) return 2;
        if ((op == `EXE_DIV_OP || op == `EXE_REM_OP)
            && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) return 2;
`endif
        return 34;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (md_valid !== exp_valid || md_result !== exp_res
                || md_wd !== exp_wd || md_wreg !== exp_wreg
                || (chk_stall && md_stallreq !== exp_stall)) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got v=%b s=%b r=%h wd=%0d wr=%b, want v=%b s=%b r=%h wd=%0d wr=%b",
                         tag, cur_cyc, md_valid, md_stallreq, md_result,
                         md_wd, md_wreg, exp_valid, exp_stall, exp_res,
                         exp_wd, exp_wreg);
            end
        end
    end

    task automatic set_exp(input logic v, input logic s, input logic cs,
                           input logic [31:0] r, input logic [4:0] w,
                           input logic wr);
        exp_valid = v;
        exp_stall = s;
        chk_stall = cs;
        exp_res   = r;
        exp_wd    = w;
        exp_wreg  = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        ex_aluop = NOP;
        for (int i = 0; i < n; i++) begin
            cur_cyc = i + 1;
            set_exp(1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
            tick();
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input logic wr,
                          input logic [31:0] lit);
        logic [31:0] r;
        int          lat;
        r   = model(op, a, b);
        lat = latency(op, a, b);
        n_tests++;
        if (r !== lit) begin
            n_fail++;
            $display("FAIL model_%s: got %h, want %h", name, r, lit);
        end
        tag      = name;
        ex_aluop = op;
        ex_reg1  = a;
        ex_reg2  = b;
        ex_wd    = wd;
        ex_wreg  = wr;
        for (int c = 1; c <= lat; c++) begin
            cur_cyc = c;
            if (c == lat) set_exp(1'b1, 1'b0, 1'b1, r, wd, wr);
            else          set_exp(1'b0, 1'b1, 1'b1, 32'd0, 5'd0, 1'b0);
            tick();
        end
        cur_cyc  = lat + 1;
        ex_aluop = NOP;
        set_exp(1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        ex_aluop = NOP;
        ex_reg1  = 32'd0;
        ex_reg2  = 32'd0;
        ex_wd    = 5'd0;
        ex_wreg  = 1'b0;
        tag      = "init";
        cur_cyc  = 0;
        set_exp(1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
        repeat (3) tick();

        // reset wins over acceptance of a 2-cycle div-by-zero
        ex_aluop = `EXE_DIVU_OP;
        ex_reg1  = 32'd5;
        ex_reg2  = 32'd0;
        ex_wd    = 5'd3;
        ex_wreg  = 1'b1;
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        tag    = "reset_state";
        idle_cycles(3);

        // flush wins over acceptance in IDLE
        tag      = "flush_accept";
        ex_aluop = `EXE_DIVU_OP;
        flush    = 1'b1;
        cur_cyc  = 1;
        set_exp(1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
        tick();
        flush = 1'b0;
        idle_cycles(3);

        run_op("div_neg7_2",   `EXE_DIV_OP,    32'hFFFF_FFF9, 32'd2,         5'd1,  1'b1, 32'hFFFF_FFFD);
        run_op("rem_neg7_2",   `EXE_REM_OP,    32'hFFFF_FFF9, 32'd2,         5'd2,  1'b1, 32'hFFFF_FFFF);
        run_op("divu_by0",     `EXE_DIVU_OP,   32'd100,       32'd0,         5'd3,  1'b1, 32'hFFFF_FFFF);
        run_op("remu_by0",     `EXE_REMU_OP,   32'd100,       32'd0,         5'd4,  1'b0, 32'd100);
        run_op("div_ovf",      `EXE_DIV_OP,    32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  1'b1, 32'h8000_0000);
        run_op("rem_ovf",      `EXE_REM_OP,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  1'b1, 32'd0);
        run_op("mulh_min",     `EXE_MULH_OP,   32'h8000_0000, 32'h8000_0000, 5'd7,  1'b1, 32'h4000_0000);
        run_op("mulhu_max",    `EXE_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b1, 32'hFFFF_FFFE);

        // flush in the 10th CALC cycle, then a clean DIVU 9/3
        tag      = "flush_calc";
        ex_aluop = `EXE_DIVU_OP;
        ex_reg1  = 32'd1000;
        ex_reg2  = 32'd7;
        ex_wd    = 5'd9;
        ex_wreg  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cur_cyc = c;
            set_exp(1'b0, 1'b1, 1'b1, 32'd0, 5'd0, 1'b0);
            tick();
        end
        cur_cyc  = 11;
        flush    = 1'b1;
        ex_aluop = NOP;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        tick();
        flush = 1'b0;
        idle_cycles(30);
        run_op("divu_9_3",     `EXE_DIVU_OP,   32'd9,         32'd3,         5'd10, 1'b1, 32'd3);

        // reset in the 5th CALC cycle of a MUL
        tag      = "rst_calc";
        ex_aluop = `EXE_MUL_OP;
        ex_reg1  = 32'd3;
        ex_reg2  = 32'd5;
        ex_wd    = 5'd11;
        ex_wreg  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cur_cyc = c;
`ifdef MULDIV_FAST_MUL_EN
            set_exp(c == 2, c == 1, 1'b1, (c == 2) ? 32'd15 : 32'd0,
                    (c == 2) ? 5'd11 : 5'd0, c == 2);
            if (c == 2) ex_aluop = NOP;
`else
            set_exp(1'b0, 1'b1, 1'b1, 32'd0, 5'd0, 1'b0);
`endif
            tick();
        end
        cur_cyc = 6;
        rst     = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;
        idle_cycles(40);

        run_op("mul_7_m3",     `EXE_MUL_OP,    32'd7,         32'hFFFF_FFFD, 5'd12, 1'b1, 32'hFFFF_FFEB);
        run_op("mulhsu_m1_2",  `EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'd2,         5'd13, 1'b1, 32'hFFFF_FFFF);
        run_op("remu_100_7",   `EXE_REMU_OP,   32'd100,       32'd7,         5'd14, 1'b0, 32'd2);
        run_op("div_100_m7",   `EXE_DIV_OP,    32'd100,       32'hFFFF_FFF9, 5'd15, 1'b1, 32'hFFFF_FFF2);
        run_op("rem_100_m7",   `EXE_REM_OP,    32'd100,       32'hFFFF_FFF9, 5'd16, 1'b1, 32'd2);
        run_op("div_0_0",      `EXE_DIV_OP,    32'd0,         32'd0,         5'd17, 1'b1, 32'hFFFF_FFFF);
        run_op("rem_m7_0",     `EXE_REM_OP,    32'hFFFF_FFF9, 32'd0,         5'd18, 1'b1, 32'hFFFF_FFF9);
        run_op("mul_12345_1k", `EXE_MUL_OP,    32'd12345,     32'd1000,      5'd19, 1'b1, 32'h00BC_5EA8);
        run_op("mulhu_2g_4",   `EXE_MULHU_OP,  32'h8000_0000, 32'd4,         5'd20, 1'b1, 32'd2);

        tag = "tail";
        idle_cycles(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have ports: clk input 1, execute-stage clock; rst input 1, reset (synchronous, active-high).
REQ-002 SHALL have input ex_aluop, width `AluOpBus; the operation from the ID/EX register; M-ops are EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP.
REQ-003 SHALL have inputs ex_reg1 32 (rs1 operand), ex_reg2 32 (rs2 operand), ex_wd 5 (destination register), ex_wreg 1 (write enable).
REQ-004 SHALL have input flush 1; it kills the in-flight op.
REQ-005 SHALL have outputs md_stallreq 1 (pipeline stall request), md_valid 1 (result valid), md_result 32, md_wd 5, md_wreg 1.

Function
REQ-006 SHALL use states IDLE, CALC and DONE.
REQ-007 IDLE with an M-op on ex_aluop and flush=0 SHALL latch the operands, op, wd and wreg, and SHALL assert md_stallreq combinationally in that cycle.
REQ-008 Accepted ops SHALL transition IDLE->CALC, except the cases in REQ-013, REQ-014 and REQ-018.
REQ-009 CALC SHALL run exactly 32 iterations, one result bit per cycle, then go to DONE; md_stallreq SHALL stay 1 throughout CALC.
REQ-010 Divide SHALL use radix-2 restoring division on magnitudes; multiply SHALL use shift-add on magnitudes with a 64-bit accumulator.
REQ-011 Signed ops SHALL negate the result when operand signs differ; REM sign SHALL follow the dividend.
REQ-012 MUL SHALL return bits [31:0] of the product; MULH, MULHSU and MULHU SHALL return bits [63:32] with signed/signed, signed/unsigned and unsigned/unsigned operands respectively.
REQ-013 Divide by zero SHALL go IDLE->DONE directly with quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-014 DIV or REM with 0x80000000 / 0xFFFFFFFF SHALL go IDLE->DONE directly with quotient 0x80000000 and remainder 0.
REQ-015 DONE SHALL drive md_valid=1, md_stallreq=0, md_result, md_wd and md_wreg for exactly one cycle, then go to IDLE; the held op SHALL NOT restart in the DONE cycle.
REQ-016 In all other cycles md_valid SHALL be 0, md_wreg 0, and md_result and md_wd 0.
REQ-017 flush=1 in any state SHALL return the block to IDLE next cycle with no md_valid pulse; flush has priority over acceptance.
REQ-018 Non-M ops SHALL be ignored, with md_stallreq=0.
REQ-019 Normal latency SHALL be 34 cycles from presentation to md_valid: 1 accept cycle, 32 CALC cycles, then DONE.

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE, clear the iteration counter and accumulators, and zero all outputs.
REQ-021 rst SHALL abort an operation mid-CALC with no md_valid pulse.
REQ-022 rst SHALL take priority over flush and acceptance.

Configuration
REQ-023 With MULDIV_FAST_MUL_EN defined, the four multiply ops SHALL compute combinationally in the accept cycle and go IDLE->DONE, giving 2-cycle latency and 1 stall cycle.
REQ-024 Without MULDIV_FAST_MUL_EN, multiplies SHALL use the 32-cycle CALC path.
REQ-025 Divide behaviour SHALL be identical with or without MULDIV_FAST_MUL_EN.

Verification
REQ-026 DIV with reg1=0xFFFFFFF9 (-7) and reg2=2 -> md_valid in cycle 34 with result 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-027 DIVU with reg1=100 and reg2=0 -> md_valid in cycle 2 with result 0xFFFFFFFF; REMU with the same operands -> 100.
REQ-028 DIV with reg1=0x80000000 and reg2=0xFFFFFFFF -> result 0x80000000 in cycle 2; REM with the same operands -> 0.
REQ-029 MULH with reg1=0x80000000 and reg2=0x80000000 -> 0x40000000; MULHU with reg1=0xFFFFFFFF and reg2=0xFFFFFFFF -> 0xFFFFFFFE; check latency 34, or 2 with MULDIV_FAST_MUL_EN.
REQ-030 Start DIVU and pulse flush in CALC cycle 10 -> no md_valid, state IDLE; a following DIVU 9/3 -> result 3 in cycle 34.
REQ-031 Start MUL and assert rst in CALC cycle 5 -> all outputs 0 next cycle and no md_valid afterwards.
